// File: rtl/uart_tx_sched.sv
// Round-robin shared 8N1 UART transmitter; bit timing from external txclk_en strobe.
module uart_tx_sched #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk_50m,
  input  logic                 reset,
  input  logic                 txclk_en,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] data,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 tx,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    START,
    DATA,
    STOP
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         shift_q, shift_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic               stop_cnt_q, stop_cnt_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [ID_W-1:0]    grant_q, grant_d;

  logic               found_hi, found_lo;
  logic [ID_W-1:0]    win_hi, win_lo, win;
  logic [7:0]         win_byte;

  // Round-robin pick: lowest set req above the pointer, else lowest set req overall
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req[i] && !found_hi && (i > 32'(ptr_q))) begin
        found_hi = 1'b1;
        win_hi   = ID_W'(i);
      end
      if (req[i] && !found_lo) begin
        found_lo = 1'b1;
        win_lo   = ID_W'(i);
      end
    end
    win      = found_hi ? win_hi : win_lo;
    win_byte = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == win) begin
        win_byte = data[8*i +: 8];
      end
    end
  end

  // Next-state and registered-output values
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    ptr_d      = ptr_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    ack_d      = '0;
    grant_d    = grant_q;
    unique case (state_q)
      IDLE: begin
        if (found_lo) begin
          shift_d = win_byte;
          grant_d = win;
          ptr_d   = win;
          busy_d  = 1'b1;
          ack_d   = NUM_REQ'(1) << win;
          state_d = WAIT_START;
        end
      end
      WAIT_START: begin
        if (txclk_en) begin
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (txclk_en) begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (txclk_en) begin
          if (bit_cnt_q == 3'd7) begin
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
            state_d    = STOP;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (txclk_en) begin
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_50m) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      ptr_q      <= ID_W'(NUM_REQ - 1);
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      ack_q      <= '0;
      grant_q    <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      ptr_q      <= ptr_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      grant_q    <= grant_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign ack      = ack_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized self-checking bench for uart_tx_sched with a frame-level reference model.
module tb_uart_tx_sched;

  logic        clk_50m = 1'b0;
  logic        reset;
  logic        txclk_en;
  logic [3:0]  req, req2;
  logic [31:0] data, data2;
  logic [3:0]  ack, ack2;
  logic        tx, tx2, busy, busy2;
  logic [1:0]  grant_id, grant2;

  logic        sel2;
  logic        tx_m, busy_m;
  logic [3:0]  ack_m;
  logic [1:0]  grant_m;

  int checks   = 0;
  int failures = 0;
  int per      = 4;
  int sc       = 0;
  int mptr     = 3;
  logic [7:0] bytes [4];

  always #5 clk_50m = ~clk_50m;

  uart_tx_sched #(.NUM_REQ(4), .STOP_BITS(1)) dut (
    .clk_50m (clk_50m),
    .reset   (reset),
    .txclk_en(txclk_en),
    .req     (req),
    .data    (data),
    .ack     (ack),
    .tx      (tx),
    .busy    (busy),
    .grant_id(grant_id)
  );

  uart_tx_sched #(.NUM_REQ(4), .STOP_BITS(2)) dut2 (
    .clk_50m (clk_50m),
    .reset   (reset),
    .txclk_en(txclk_en),
    .req     (req2),
    .data    (data2),
    .ack     (ack2),
    .tx      (tx2),
    .busy    (busy2),
    .grant_id(grant2)
  );

  assign tx_m    = sel2 ? tx2 : tx;
  assign busy_m  = sel2 ? busy2 : busy;
  assign ack_m   = sel2 ? ack2 : ack;
  assign grant_m = sel2 ? grant2 : grant_id;

  // One clock; baud strobe prepared for the following edge
  task automatic tick();
    @(posedge clk_50m);
    #1;
    sc++;
    if (per != 0) txclk_en = ((sc % per) == 0);
    else          txclk_en = 1'b0;
  endtask

  function automatic int pick(input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(mptr + k) % 4]) return (mptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic set_byte(input int i, input logic [7:0] b);
    data[8*i +: 8] = b;
    bytes[i] = b;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    req2 = '0;
    tick();
    tick();
    reset = 1'b0;
    mptr = 3;
  endtask

  task automatic expect_grant(input int exp_id);
    logic [3:0] oh;
    int n;
    oh = 4'b0001 << exp_id;
    n = 0;
    while (ack_m == 4'b0000 && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (ack_m !== oh || grant_m !== 2'(exp_id) || busy_m !== 1'b1) begin
      failures++;
      $display("FAIL grant: ack=%b grant_id=%0d busy=%b, required ack=%b grant_id=%0d busy=1",
               ack_m, grant_m, busy_m, oh, exp_id);
    end
    mptr = exp_id;
  endtask

  // Each strobe after acceptance advances one line level: start, 8 data LSB-first, stops
  task automatic check_frame(input logic [7:0] b, input int nstop);
    logic lv[$];
    logic strobe;
    logic exp_tx;
    int k;
    lv.push_back(1'b0);
    for (int i = 0; i < 8; i++) lv.push_back(b[i]);
    for (int i = 0; i < nstop; i++) lv.push_back(1'b1);
    k = -1;
    for (int n = 0; n < 400; n++) begin
      strobe = txclk_en;
      tick();
      if (strobe) k++;
      checks++;
      if (k == lv.size()) begin
        if (busy_m !== 1'b0 || tx_m !== 1'b1) begin
          failures++;
          $display("FAIL frame_end: busy=%b tx=%b, required busy=0 tx=1 (byte %h)", busy_m, tx_m, b);
        end
        return;
      end
      exp_tx = (k < 0) ? 1'b1 : lv[k];
      if (busy_m !== 1'b1 || tx_m !== exp_tx || ack_m !== 4'b0000) begin
        failures++;
        $display("FAIL frame_bit: period=%0d busy=%b tx=%b ack=%b, required busy=1 tx=%b ack=0000 (byte %h)",
                 k, busy_m, tx_m, ack_m, exp_tx, b);
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL frame_timeout: frame of byte %h did not finish, required finish", b);
  endtask

  task automatic test_reset();
    txclk_en = 1'b0;
    do_reset();
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || ack !== 4'b0000 || grant_id !== 2'd0) begin
      failures++;
      $display("FAIL reset: tx=%b busy=%b ack=%b grant_id=%0d, required tx=1 busy=0 ack=0000 grant_id=0",
               tx, busy, ack, grant_id);
    end
    checks++;
    if (tx2 !== 1'b1 || busy2 !== 1'b0 || ack2 !== 4'b0000 || grant2 !== 2'd0) begin
      failures++;
      $display("FAIL reset2: tx=%b busy=%b ack=%b grant_id=%0d, required tx=1 busy=0 ack=0000 grant_id=0",
               tx2, busy2, ack2, grant2);
    end
  endtask

  task automatic test_single_byte();
    per = 4;
    sc = 0;
    set_byte(2, 8'hA5);
    req = 4'b0100;
    expect_grant(pick(req));
    req = 4'b0000;
    check_frame(8'hA5, 1);
    for (int n = 0; n < 12; n++) begin
      tick();
      checks++;
      if (ack !== 4'b0000 || busy !== 1'b0 || tx !== 1'b1) begin
        failures++;
        $display("FAIL idle_after_single: ack=%b busy=%b tx=%b, required ack=0000 busy=0 tx=1", ack, busy, tx);
      end
    end
  endtask

  task automatic test_fairness();
    int g;
    logic [7:0] b;
    per = $urandom_range(3, 6);
    for (int i = 0; i < 4; i++) set_byte(i, 8'($urandom));
    req = 4'b1111;
    for (int f = 0; f < 8; f++) begin
      g = pick(req);
      expect_grant(g);
      b = bytes[g];
      if (f == 3) req = 4'b0101;
      if (f == 7) req = 4'b0000;
      else        set_byte(g, 8'($urandom));
      check_frame(b, 1);
    end
  endtask

  task automatic test_stop_bits_2();
    do_reset();
    sel2 = 1'b1;
    per = 4;
    sc = 0;
    data2 = '0;
    req2 = 4'b0001;
    expect_grant(pick(req2));
    req2 = 4'b0000;
    check_frame(8'h00, 2);
    sel2 = 1'b0;
    do_reset();
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    logic strobe;
    int k;
    per = 4;
    sc = 0;
    b = 8'($urandom);
    set_byte(1, b);
    req = 4'b0010;
    expect_grant(pick(req));
    req = 4'b0000;
    k = -1;
    for (int n = 0; n < 200 && k < 4; n++) begin
      strobe = txclk_en;
      tick();
      if (strobe) k++;
    end
    checks++;
    if (k != 4 || busy !== 1'b1 || tx !== b[3]) begin
      failures++;
      $display("FAIL mid_frame_bit3: reached=%0d busy=%b tx=%b, required reached=4 busy=1 tx=%b", k, busy, tx, b[3]);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mptr = 3;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || ack !== 4'b0000) begin
      failures++;
      $display("FAIL mid_frame_reset: tx=%b busy=%b ack=%b, required tx=1 busy=0 ack=0000", tx, busy, ack);
    end
    set_byte(0, 8'($urandom));
    set_byte(1, 8'($urandom));
    req = 4'b0011;
    expect_grant(pick(req));
    req = 4'b0010;
    check_frame(bytes[0], 1);
    expect_grant(pick(req));
    req = 4'b0000;
    check_frame(bytes[1], 1);
  endtask

  task automatic test_stalled_baud();
    logic [2:0] r;
    logic [7:0] b;
    per = 0;
    txclk_en = 1'b0;
    b = 8'($urandom);
    set_byte(0, b);
    req = 4'b0001;
    expect_grant(pick(req));
    for (int n = 0; n < 30; n++) begin
      r = 3'($urandom_range(0, 7));
      req = {r, 1'b0};
      tick();
      checks++;
      if (tx !== 1'b1 || busy !== 1'b1 || ack !== 4'b0000 || grant_id !== 2'd0) begin
        failures++;
        $display("FAIL stalled: tx=%b busy=%b ack=%b grant_id=%0d, required tx=1 busy=1 ack=0000 grant_id=0",
                 tx, busy, ack, grant_id);
      end
    end
    req = 4'b0000;
    per = 4;
    sc = 0;
    check_frame(b, 1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    per = $urandom_range(2, 5);
    set_byte(0, 8'($urandom));
    req = 4'b0001;
    for (int f = 0; f < 4; f++) begin
      expect_grant(pick(req));
      b = bytes[0];
      if (f == 3) req = 4'b0000;
      else        set_byte(0, 8'($urandom));
      check_frame(b, 1);
    end
  endtask

  initial begin
    sel2 = 1'b0;
    reset = 1'b0;
    txclk_en = 1'b0;
    req = '0;
    req2 = '0;
    data = '0;
    data2 = '0;
    for (int i = 0; i < 4; i++) bytes[i] = '0;
    test_reset();
    test_single_byte();
    test_fairness();
    test_stop_bits_2();
    test_reset_mid_frame();
    test_stalled_baud();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
